// File: rtl/network_sync_controller_pkg.sv
// Shared controller types for the generated actor network (package TriggerTypes).
// Imported by the network_sync_controller top and its quiescence detector.
package TriggerTypes;

    typedef enum logic [2:0] {
        CTRL_IDLE      = 3'd0,
        CTRL_RUN       = 3'd1,
        CTRL_SYNC_REQ  = 3'd2,
        CTRL_SYNC_EVAL = 3'd3,
        CTRL_DONE      = 3'd4
    } ctrl_state_t;

    // Counter width that can hold 0..quiesce_cycles inclusive.
    function automatic int qcnt_width(input int quiesce_cycles);
        return (quiesce_cycles < 1) ? 1 : $clog2(quiesce_cycles + 1);
    endfunction

endpackage

// File: rtl/network_sync_controller_quiescence_detector.sv
// Counts consecutive all-sleep cycles while enabled; quiet flags the cycle that
// completes a run of QUIESCE_CYCLES.
module quiescence_detector
    import TriggerTypes::*;
#(
    parameter int QUIESCE_CYCLES = 8
) (
    input  logic ap_clk,
    input  logic ap_rst,
    input  logic en,
    input  logic all_sleep_in,
    input  logic clr,
    output logic quiet
);

    localparam int QW = qcnt_width(QUIESCE_CYCLES);
    localparam logic [QW-1:0] QCNT_MAX  = QW'(QUIESCE_CYCLES);
    localparam logic [QW-1:0] QCNT_LAST = QW'(QUIESCE_CYCLES - 1);

    logic [QW-1:0] qcnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge ap_clk) begin
        if (ap_rst || clr) begin
            qcnt <= '0;
        end else if (en) begin
            if (all_sleep_in) begin
                if (qcnt != QCNT_MAX) begin
                    qcnt <= qcnt + 1'b1;
                end
            end else begin
                qcnt <= '0;
            end
        end
    end

    // The current cycle is itself the last sleeping cycle of the run.
    assign quiet = en & all_sleep_in & (qcnt == QCNT_LAST);

endmodule

// File: rtl/network_sync_controller.sv
// Network-level start / quiescence / sync-barrier / done sequencer for actor triggers.
// Optional performance counters are enabled with `define NETWORK_PERF_CNT_EN.
module network_sync_controller
    import TriggerTypes::*;
#(
    parameter int NUM_ACTORS     = 4,
    parameter int QUIESCE_CYCLES = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    output logic [NUM_ACTORS-1:0] actor_start,
    input  logic [NUM_ACTORS-1:0] actor_sleep,
    input  logic [NUM_ACTORS-1:0] actor_sync_wait,
    input  logic [NUM_ACTORS-1:0] actor_sync_exec,
    output logic                  all_sleep,
    output logic                  all_sync_wait,
    output logic                  all_sync_exec
`ifdef NETWORK_PERF_CNT_EN
    ,
    output logic [63:0]           run_cycles,
    output logic [31:0]           sync_rounds
`endif
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic        exec_seen;
    logic        quiet;
    logic        every_sleep;
    logic        every_wait;
    logic        any_exec;
    logic        resume;

    assign every_sleep = &actor_sleep;
    assign every_wait  = &actor_sync_wait;
    assign any_exec    = |actor_sync_exec;
    // An execution reported in the evaluation cycle itself still counts.
    assign resume      = exec_seen | any_exec;

    quiescence_detector #(
        .QUIESCE_CYCLES (QUIESCE_CYCLES)
    ) u_quiescence_detector (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .en           (state == CTRL_RUN),
        .all_sleep_in (every_sleep),
        .clr          (state != CTRL_RUN),
        .quiet        (quiet)
    );

    // NOTE: next-state defaults to the current state before the case so no path
    // leaves state_next unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            CTRL_IDLE:      if (ap_start)   state_next = CTRL_RUN;
            CTRL_RUN:       if (quiet)      state_next = CTRL_SYNC_REQ;
            CTRL_SYNC_REQ:  if (every_wait) state_next = CTRL_SYNC_EVAL;
            CTRL_SYNC_EVAL: state_next = resume ? CTRL_RUN : CTRL_DONE;
            CTRL_DONE:      state_next = CTRL_IDLE;
            default:        state_next = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= CTRL_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Executions are sticky across the whole barrier, including its closing cycle.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            exec_seen <= 1'b0;
        end else if (state == CTRL_SYNC_REQ) begin
            exec_seen <= exec_seen | any_exec;
        end else if (state == CTRL_SYNC_EVAL) begin
            exec_seen <= 1'b0;
        end
    end

    assign ap_idle       = (state == CTRL_IDLE);
    assign ap_done       = (state == CTRL_DONE);
    assign ap_ready      = (state == CTRL_DONE);
    assign all_sleep     = (state == CTRL_SYNC_REQ);
    assign all_sync_wait = (state == CTRL_SYNC_EVAL);
    assign all_sync_exec = (state == CTRL_SYNC_EVAL) & resume;
    assign actor_start   = ((state == CTRL_RUN) || (state == CTRL_SYNC_REQ) ||
                            (state == CTRL_SYNC_EVAL)) ? {NUM_ACTORS{1'b1}}
                                                       : {NUM_ACTORS{1'b0}};

`ifdef NETWORK_PERF_CNT_EN
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            run_cycles  <= '0;
            sync_rounds <= '0;
        end else if ((state == CTRL_IDLE) && ap_start) begin
            run_cycles  <= '0;
            sync_rounds <= '0;
        end else begin
            if (state != CTRL_IDLE) begin
                run_cycles <= run_cycles + 64'd1;
            end
            if (state == CTRL_SYNC_EVAL) begin
                sync_rounds <= sync_rounds + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_network_sync_controller.sv
// Self-checking bench for network_sync_controller (NUM_ACTORS=4, QUIESCE_CYCLES=3).
// Perf-counter checks compile in when NETWORK_PERF_CNT_EN is defined.
module tb_network_sync_controller;

    localparam int N = 4;
    localparam int Q = 3;

    logic         ap_clk = 1'b0;
    logic         ap_rst = 1'b1;
    logic         ap_start = 1'b0;
    logic         ap_done, ap_idle, ap_ready;
    logic [N-1:0] actor_start;
    logic [N-1:0] actor_sleep = '0;
    logic [N-1:0] actor_sync_wait = '0;
    logic [N-1:0] actor_sync_exec = '0;
    logic         all_sleep, all_sync_wait, all_sync_exec;
`ifdef NETWORK_PERF_CNT_EN
    logic [63:0]  run_cycles;
    logic [31:0]  sync_rounds;
`endif

    network_sync_controller #(
        .NUM_ACTORS     (N),
        .QUIESCE_CYCLES (Q)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .ap_idle         (ap_idle),
        .ap_ready        (ap_ready),
        .actor_start     (actor_start),
        .actor_sleep     (actor_sleep),
        .actor_sync_wait (actor_sync_wait),
        .actor_sync_exec (actor_sync_exec),
        .all_sleep       (all_sleep),
        .all_sync_wait   (all_sync_wait),
        .all_sync_exec   (all_sync_exec)
`ifdef NETWORK_PERF_CNT_EN
        ,
        .run_cycles      (run_cycles),
        .sync_rounds     (sync_rounds)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_count = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a network is either inactive, running (counting a
    // sleep streak), inside a barrier, evaluating it, or finishing.
    bit              m_active, m_barrier, m_eval, m_finish, m_fired;
    int              m_streak;
    longint unsigned m_run;
    int unsigned     m_rounds;

    initial begin
        forever begin
            @(posedge ap_clk);
            if (ap_rst) begin
                m_active = 0; m_barrier = 0; m_eval = 0; m_finish = 0; m_fired = 0;
                m_streak = 0; m_run = 0; m_rounds = 0;
            end else begin
                if (m_active) m_run = m_run + 1;
                if (m_eval)   m_rounds = m_rounds + 1;
                if (!m_active) begin
                    if (ap_start) begin
                        m_active = 1; m_streak = 0; m_run = 0; m_rounds = 0;
                    end
                end else if (m_finish) begin
                    m_finish = 0;
                    m_active = 0;
                end else if (m_eval) begin
                    m_eval = 0;
                    if (!(m_fired || (|actor_sync_exec))) m_finish = 1;
                    m_fired  = 0;
                    m_streak = 0;
                end else if (m_barrier) begin
                    m_fired = m_fired | (|actor_sync_exec);
                    if (&actor_sync_wait) begin
                        m_barrier = 0;
                        m_eval    = 1;
                    end
                end else if (&actor_sleep) begin
                    m_streak = m_streak + 1;
                    if (m_streak == Q) m_barrier = 1;
                end else begin
                    m_streak = 0;
                end
            end
        end
    end

    // Per-cycle compare against the model, mid-cycle.
    logic [N-1:0] e_start;
    initial begin
        forever begin
            @(negedge ap_clk);
            if (ap_done === 1'b1) done_count++;
            if (cmp_en) begin
                e_start = (m_active && !m_finish) ? {N{1'b1}} : {N{1'b0}};
                check("model ap_idle",       ap_idle,       !m_active);
                check("model ap_done",       ap_done,       m_finish);
                check("model ap_ready",      ap_ready,      m_finish);
                check("model actor_start",   actor_start,   e_start);
                check("model all_sleep",     all_sleep,     m_barrier);
                check("model all_sync_wait", all_sync_wait, m_eval);
                check("model all_sync_exec", all_sync_exec,
                      m_eval && (m_fired || (|actor_sync_exec)));
`ifdef NETWORK_PERF_CNT_EN
                check("model run_cycles",    run_cycles,    m_run);
                check("model sync_rounds",   sync_rounds,   m_rounds);
`endif
            end
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
        cyc++;
    endtask

    // sel 0: wait for all_sleep, sel 1: wait for ap_done.
    task automatic wait_sig(input int sel, input string name);
        bit hit = 1'b0;
        int budget = 0;
        while (!hit && budget < 60) begin
            step();
            budget++;
            hit = (sel == 0) ? (all_sleep === 1'b1) : (ap_done === 1'b1);
        end
        if (!hit) check({"timeout ", name}, 64'd0, 64'd1);
    endtask

    task automatic clear_inputs();
        ap_start = 0; actor_sleep = '0; actor_sync_wait = '0; actor_sync_exec = '0;
    endtask

    task automatic finish_run(input string name);
        actor_sync_wait = '1;
        wait_sig(1, name);
        clear_inputs();
        step();
    endtask

    int base;
    int start_cyc;
    int done_cyc;

    initial begin
        step();
        cmp_en = 1'b1;
        step();
        ap_rst = 1'b0;
        check("reset ap_idle", ap_idle, 1'b1);
        check("reset actor_start", actor_start, 4'h0);
        check("reset all_sleep", all_sleep, 1'b0);
        check("reset ap_done", ap_done, 1'b0);

        // 1. Termination with minimum quiescence.
        ap_start = 1; step();
        ap_start = 0; actor_sleep = 4'hF;
        check("s1 running", ap_idle, 1'b0);
        check("s1 actor_start", actor_start, 4'hF);
        step(); step();
        check("s1 still counting", all_sleep, 1'b0);
        step();
        check("s1 all_sleep", all_sleep, 1'b1);
        step(); step();
        actor_sync_wait = 4'hF;
        step();
        check("s1 sync_wait", all_sync_wait, 1'b1);
        check("s1 no sync_exec", all_sync_exec, 1'b0);
        step();
        check("s1 ap_done", ap_done, 1'b1);
        check("s1 ap_ready", ap_ready, 1'b1);
        check("s1 start dropped", actor_start, 4'h0);
        step();
        check("s1 idle after", ap_idle, 1'b1);
        check("s1 done pulse", ap_done, 1'b0);
        clear_inputs(); step();
        check("s1 done once", done_count, 1);

        // 2. Quiescence streak restarts on a sleep drop.
        ap_start = 1; step();
        ap_start = 0; actor_sleep = 4'hF;
        step(); step();
        actor_sleep = 4'h7; step();
        check("s2 broken streak", all_sleep, 1'b0);
        actor_sleep = 4'hF; step(); step();
        check("s2 two new cycles", all_sleep, 1'b0);
        step();
        check("s2 all_sleep", all_sleep, 1'b1);
        finish_run("s2 done");

        // 3/6. Sync resume followed by termination.
        base = done_count;
        ap_start = 1; step();
        start_cyc = cyc;
        ap_start = 0; actor_sleep = 4'hF;
        wait_sig(0, "s3 sleep");
        actor_sync_exec = 4'b0100; step();
        actor_sync_exec = '0; actor_sync_wait = 4'hF; step();
        check("s3 sync_wait", all_sync_wait, 1'b1);
        check("s3 sync_exec", all_sync_exec, 1'b1);
        step();
        check("s3 back to run", all_sleep, 1'b0);
        check("s3 not idle", ap_idle, 1'b0);
        check("s3 actor_start", actor_start, 4'hF);
        check("s3 no done", done_count, base);
        actor_sync_wait = '0;
        wait_sig(0, "s3 second sleep");
        actor_sync_wait = 4'hF;
        wait_sig(1, "s3 done");
        done_cyc = cyc;
        clear_inputs(); step();
`ifdef NETWORK_PERF_CNT_EN
        check("s6 sync_rounds", sync_rounds, 32'd2);
        check("s6 run_cycles", run_cycles, 64'(done_cyc - start_cyc + 1));
`endif

        // 4. Reset during the barrier aborts silently.
        base = done_count;
        ap_start = 1; step();
        ap_start = 0; actor_sleep = 4'hF;
        wait_sig(0, "s4 sleep");
        ap_rst = 1; step();
        check("s4 idle", ap_idle, 1'b1);
        check("s4 all_sleep", all_sleep, 1'b0);
        check("s4 actor_start", actor_start, 4'h0);
        ap_rst = 0; clear_inputs(); step(); step();
        check("s4 no done", done_count, base);

        // 5. Start held through DONE restarts after one idle cycle.
        ap_start = 1; step();
        actor_sleep = 4'hF; actor_sync_wait = 4'hF;
        wait_sig(1, "s5 done");
        step();
        check("s5 idle gap", ap_idle, 1'b1);
        step();
        check("s5 rerun", ap_idle, 1'b0);
        check("s5 rerun start", actor_start, 4'hF);
        ap_start = 0;
        wait_sig(1, "s5 second done");
        clear_inputs(); step();
        check("s5 final idle", ap_idle, 1'b1);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
